// File: rtl/harness_cmd_encoder.sv
// harness_cmd_encoder
//
// Host-side end of the simulation-harness byte protocol. Turns high-level
// test requests (SAMPLE, QUIT, RST_ASSERT, RST_DEASSERT, STEP, LOAD) into the
// single-byte command stream the harness consumes. It also reassembles the
// harness's little-endian response bytes into one output vector.
//
// Ports
//   clk, rst          clock; asynchronous active-low reset
//   req_valid/ready   request handshake
//   req_op            0 SAMPLE, 1 QUIT, 2 RST_ASSERT, 3 RST_DEASSERT,
//                     4 STEP, 5 LOAD (6/7 invalid)
//   req_data          LOAD payload, sent least-significant byte first
//   req_count         STEP repeat count
//   tx_valid/ready    command byte handshake, tx_byte = command byte
//   rx_valid, rx_byte response byte strobe (no backpressure)
//   rsp_valid         one-cycle pulse when rsp_data is updated
//   rsp_data          last sampled output vector (word 0 in the low bits)
//   err               one-cycle pulse on an invalid op or a response timeout
//   halted            sticky once QUIT has been sent, cleared only by reset
//
// Optional feature: define HARNESS_CMD_TIMEOUT_EN to add a 1024-cycle
// watchdog in WAIT_RSP. It abandons a sample when response bytes stop arriving.

module harness_cmd_encoder #(
  parameter int INPUT_BYTES  = 4,
  parameter int OUTPUT_WORDS = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [2:0]                req_op,
  input  logic [INPUT_BYTES*8-1:0]  req_data,
  input  logic [7:0]                req_count,
  output logic                      tx_valid,
  input  logic                      tx_ready,
  output logic [7:0]                tx_byte,
  input  logic                      rx_valid,
  input  logic [7:0]                rx_byte,
  output logic                      rsp_valid,
  output logic [OUTPUT_WORDS*32-1:0] rsp_data,
  output logic                      err,
  output logic                      halted
);

  localparam int DW = INPUT_BYTES * 8;
  localparam int RW = OUTPUT_WORDS * 32;
  localparam logic [15:0] LOAD_CNT = 16'(INPUT_BYTES);
  localparam logic [15:0] RSP_CNT  = 16'(OUTPUT_WORDS * 4);

  localparam logic [2:0] OP_SAMPLE = 3'd0;
  localparam logic [2:0] OP_QUIT   = 3'd1;
  localparam logic [2:0] OP_STEP   = 3'd4;
  localparam logic [2:0] OP_LOAD   = 3'd5;
  // Command byte for op N is 104 + N.
  localparam logic [7:0] OP_BASE   = 8'd104;

  typedef enum logic [2:0] {
    S_IDLE, S_SEND_OP, S_SEND_DATA, S_WAIT_RSP, S_HALTED
  } state_t;

  state_t          state, state_nxt;
  logic            live;
  logic [2:0]      op_q;
  logic [DW-1:0]   data_q;
  logic [15:0]     cnt;
  logic [RW-1:0]   stage;

  logic accept, op_ok, tx_fire, rx_take, rx_last, timeout;

  assign accept  = req_valid & req_ready;
  assign op_ok   = (req_op <= 3'd5);
  assign tx_fire = tx_valid & tx_ready;
  assign rx_take = (state == S_WAIT_RSP) & rx_valid;
  assign rx_last = rx_take & (cnt == 16'd1);

`ifdef HARNESS_CMD_TIMEOUT_EN
  logic [9:0] wd;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd <= 10'd0;
    end else if (state != S_WAIT_RSP || rx_valid) begin
      wd <= 10'd0;
    end else begin
      wd <= wd + 10'd1;
    end
  end

  // Fires on the 1024th consecutive silent cycle in WAIT_RSP.
  assign timeout = (state == S_WAIT_RSP) & ~rx_valid & (wd == 10'h3FF);
`else
  assign timeout = 1'b0;
`endif

  // State register and control counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      live      <= 1'b0;
      cnt       <= 16'd0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      live      <= 1'b1;
      rsp_valid <= rx_last;
      err       <= (accept & ~op_ok) | timeout;
      if (rx_last) begin
        rsp_data <= {rx_byte, stage[RW-1:8]};
      end
      if (accept) begin
        cnt <= {8'd0, req_count};
      end else if (state == S_SEND_OP && tx_fire) begin
        case (op_q)
          OP_LOAD:   cnt <= LOAD_CNT;
          OP_SAMPLE: cnt <= RSP_CNT;
          default:   cnt <= cnt - 16'd1;
        endcase
      end else if ((state == S_SEND_DATA && tx_fire) || rx_take) begin
        cnt <= cnt - 16'd1;
      end
    end
  end

  // Payload and response staging
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q   <= req_op;
      data_q <= req_data;
    end else if (state == S_SEND_DATA && tx_fire) begin
      data_q <= data_q >> 8;
    end
    // Bytes arrive least-significant first, so shift in from the top.
    if (rx_take) begin
      stage <= {rx_byte, stage[RW-1:8]};
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        // STEP with a zero count emits nothing and never leaves IDLE.
        if (accept && op_ok && !(req_op == OP_STEP && req_count == 8'd0)) begin
          state_nxt = S_SEND_OP;
        end
      end
      S_SEND_OP: begin
        if (tx_fire) begin
          case (op_q)
            OP_LOAD:   state_nxt = S_SEND_DATA;
            OP_SAMPLE: state_nxt = S_WAIT_RSP;
            OP_QUIT:   state_nxt = S_HALTED;
            OP_STEP:   state_nxt = (cnt == 16'd1) ? S_IDLE : S_SEND_OP;
            default:   state_nxt = S_IDLE;
          endcase
        end
      end
      S_SEND_DATA: begin
        if (tx_fire && cnt == 16'd1) begin
          state_nxt = S_IDLE;
        end
      end
      S_WAIT_RSP: begin
        if (rx_last || timeout) begin
          state_nxt = S_IDLE;
        end
      end
      S_HALTED:  state_nxt = S_HALTED;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    req_ready = live & (state == S_IDLE);
    tx_valid  = (state == S_SEND_OP) | (state == S_SEND_DATA);
    halted    = (state == S_HALTED);
    case (state)
      S_SEND_OP:   tx_byte = OP_BASE + {5'd0, op_q};
      S_SEND_DATA: tx_byte = data_q[7:0];
      default:     tx_byte = 8'd0;
    endcase
  end

endmodule

// File: tb/tb_harness_cmd_encoder.sv
// Testbench for harness_cmd_encoder (INPUT_BYTES=4, OUTPUT_WORDS=2).
// Table-driven command-byte vectors plus hand-written sequences for
// sampling, invalid ops, QUIT/halt, mid-operation reset and the optional
// response timeout.

module tb_harness_cmd_encoder;

  localparam int IB = 4;
  localparam int OW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_op;
  logic [IB*8-1:0]   req_data;
  logic [7:0]        req_count;
  logic              tx_valid;
  logic              tx_ready;
  logic [7:0]        tx_byte;
  logic              rx_valid;
  logic [7:0]        rx_byte;
  logic              rsp_valid;
  logic [OW*32-1:0]  rsp_data;
  logic              err;
  logic              halted;

  harness_cmd_encoder #(.INPUT_BYTES(IB), .OUTPUT_WORDS(OW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_data(req_data), .req_count(req_count),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_byte(tx_byte),
    .rx_valid(rx_valid), .rx_byte(rx_byte),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .err(err), .halted(halted)
  );

  always #5 clk = ~clk;

  int nvec  = 0;
  int nfail = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] data;
    logic [7:0]  count;
    int          nbytes;
    logic [63:0] bytes;   // expected byte i in bits [8*i +: 8]
    bit          toggle;  // alternate tx_ready 1/0
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_req(input logic [2:0] op, input logic [31:0] data, input logic [7:0] count);
    int k = 0;
    while (!req_ready && k < 50) begin
      tick();
      k++;
    end
    chk("req_ready_before_accept", req_ready, 1);
    req_valid = 1'b1;
    req_op    = op;
    req_data  = data;
    req_count = count;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic run_bytes(input int n, input logic [63:0] exp, input bit toggle, input string nm);
    int got = 0;
    int cyc = 0;
    logic [7:0] held = 8'd0;
    bit stalled = 1'b0;
    bit ph = 1'b1;
    while (got < n && cyc < 200) begin
      tx_ready = toggle ? ph : 1'b1;
      ph = ~ph;
      if (stalled && tx_valid) chk({nm, "_stable"}, tx_byte, held);
      if (tx_valid) begin
        chk({nm, "_req_ready_busy"}, req_ready, 0);
        if (tx_ready) begin
          chk($sformatf("%s_byte%0d", nm, got), tx_byte, exp[8*got +: 8]);
          got++;
          stalled = 1'b0;
        end else begin
          held = tx_byte;
          stalled = 1'b1;
        end
      end
      tick();
      cyc++;
    end
    if (got < n) begin
      nvec++;
      nfail++;
      $display("FAIL %s_timeout: got %0d bytes expected %0d", nm, got, n);
    end
    tx_ready = 1'b1;
  endtask

  logic [7:0] rxb [8];

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_op = 3'd0; req_data = '0; req_count = 8'd0;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_byte = 8'd0;

    tbl[0] = '{3'd2, 32'h0,        8'd0, 1, 64'h6A,               1'b0};
    tbl[1] = '{3'd4, 32'h0,        8'd3, 3, 64'h6C6C6C,           1'b0};
    tbl[2] = '{3'd3, 32'h0,        8'd0, 1, 64'h6B,               1'b0};
    tbl[3] = '{3'd5, 32'hA1B2C3D4, 8'd0, 5, 64'hA1B2C3D46D,       1'b1};
    tbl[4] = '{3'd4, 32'h0,        8'd1, 1, 64'h6C,               1'b0};
    tbl[5] = '{3'd5, 32'h00FF0180, 8'd0, 5, 64'h00FF01806D,       1'b0};

    rxb[0] = 8'h78; rxb[1] = 8'h56; rxb[2] = 8'h34; rxb[3] = 8'h12;
    rxb[4] = 8'hEF; rxb[5] = 8'hBE; rxb[6] = 8'hAD; rxb[7] = 8'hDE;

    // Reset state
    #12;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_byte", tx_byte, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_err", err, 0);
    chk("rst_halted", halted, 0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("req_ready_after_rst", req_ready, 1);

    // Command byte vectors
    for (int i = 0; i < 6; i++) begin
      send_req(tbl[i].op, tbl[i].data, tbl[i].count);
      chk($sformatf("v%0d_busy_after_accept", i), req_ready, 0);
      run_bytes(tbl[i].nbytes, tbl[i].bytes, tbl[i].toggle, $sformatf("v%0d", i));
      chk($sformatf("v%0d_tx_idle", i), tx_valid, 0);
      chk($sformatf("v%0d_ready_again", i), req_ready, 1);
    end

    // Invalid op, then zero-count STEP
    send_req(3'd6, 32'h0, 8'd0);
    chk("inv_err", err, 1);
    chk("inv_tx_valid", tx_valid, 0);
    chk("inv_req_ready", req_ready, 1);
    tick();
    chk("inv_err_pulse", err, 0);
    send_req(3'd4, 32'h0, 8'd0);
    chk("step0_tx_valid", tx_valid, 0);
    chk("step0_req_ready", req_ready, 1);
    chk("step0_err", err, 0);
    tick();
    chk("step0_tx_valid2", tx_valid, 0);

    // rx outside WAIT_RSP is ignored
    rx_valid = 1'b1; rx_byte = 8'h55;
    tick();
    tick();
    rx_valid = 1'b0;
    chk("rx_idle_rsp_valid", rsp_valid, 0);
    chk("rx_idle_rsp_data", rsp_data, 0);

    // SAMPLE, with a gap in the response stream
    send_req(3'd0, 32'h0, 8'd0);
    run_bytes(1, 64'h68, 1'b0, "sample_op");
    chk("sample_wait_busy", req_ready, 0);
    for (int i = 0; i < 8; i++) begin
      rx_valid = 1'b1;
      rx_byte  = rxb[i];
      tick();
      if (i < 7) chk($sformatf("sample_no_rsp%0d", i), rsp_valid, 0);
      if (i == 3) begin
        rx_valid = 1'b0;
        tick();
        chk("sample_gap_no_rsp", rsp_valid, 0);
      end
    end
    rx_valid = 1'b0;
    chk("sample_rsp_valid", rsp_valid, 1);
    chk("sample_rsp_data", rsp_data, 64'hDEADBEEF_12345678);
    chk("sample_ready", req_ready, 1);
    tick();
    chk("sample_rsp_pulse", rsp_valid, 0);
    chk("sample_rsp_hold", rsp_data, 64'hDEADBEEF_12345678);

`ifdef HARNESS_CMD_TIMEOUT_EN
    begin
      int k = 0;
      send_req(3'd0, 32'h0, 8'd0);
      run_bytes(1, 64'h68, 1'b0, "tmo_op");
      rx_valid = 1'b1; rx_byte = 8'h11;
      tick();
      rx_byte = 8'h22;
      tick();
      rx_valid = 1'b0;
      while (!err && k < 1100) begin
        tick();
        k++;
      end
      chk("tmo_cycles", k, 1024);
      chk("tmo_rsp_valid", rsp_valid, 0);
      chk("tmo_rsp_data", rsp_data, 64'hDEADBEEF_12345678);
      chk("tmo_ready", req_ready, 1);
    end
`endif

    // QUIT then held request
    send_req(3'd1, 32'h0, 8'd0);
    run_bytes(1, 64'h69, 1'b0, "quit");
    chk("quit_halted", halted, 1);
    chk("quit_ready", req_ready, 0);
    req_valid = 1'b1; req_op = 3'd4; req_count = 8'd2;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("halt_tx%0d", i), tx_valid, 0);
      chk($sformatf("halt_ready%0d", i), req_ready, 0);
    end
    req_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("halt_rst_clear", halted, 0);
    chk("halt_rst_rsp_data", rsp_data, 0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("halt_recover_ready", req_ready, 1);
    send_req(3'd4, 32'h0, 8'd1);
    run_bytes(1, 64'h6C, 1'b0, "post_halt_step");
    chk("post_halt_ready", req_ready, 1);

    // Reset in the middle of a LOAD
    send_req(3'd5, 32'h11223344, 8'd0);
    tx_ready = 1'b0;
    tick();
    chk("midload_stall_valid", tx_valid, 1);
    chk("midload_stall_byte", tx_byte, 8'h6D);
    tx_ready = 1'b1;
    tick();
    chk("midload_first_data", tx_byte, 8'h44);
    tx_ready = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("midload_rst_valid", tx_valid, 0);
    chk("midload_rst_byte", tx_byte, 0);
    chk("midload_rst_ready", req_ready, 0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("midload_recover_ready", req_ready, 1);
    chk("midload_recover_tx", tx_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
